// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Central pipeline hazard detector. Produces per-stage stall and
//             flush request vectors and the halt indication consumed by the
//             pipeline control unit (which turns them into keep/dirty).
//             Detects load-use hazards, EX-resolved branch/jump redirects,
//             multi-cycle MDU occupancy of EX and data-memory wait states,
//             and sequences the processor halt (drain, then freeze).
//             Stage index: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
//  Ports    : clk             - system clock, rising edge
//             rst             - asynchronous active-low reset
//             id_rs, id_rt    - source register fields of the ID instruction
//             id_uses_rt      - ID instruction reads rt
//             id_halt         - ID holds a valid halt instruction
//             ex_rd           - destination register of the EX instruction
//             ex_mem_read     - EX instruction is a load
//             ex_branch_taken - EX resolved a taken branch/jump
//             ex_mdu_start    - EX holds a valid mul/div (level)
//             mem_wait        - data memory not ready, MEM must hold
//             stall[4:0]      - one-hot-or-zero stall (bit i holds 0..i)
//             flush[4:0]      - flush request (bit i squashes 0..i)
//             hlt             - processor halted, freezes MEM/WB
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MDU_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_halt,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       ex_mdu_start,
    input  logic       mem_wait,
    output logic [4:0] stall,
    output logic [4:0] flush,
    output logic       hlt
);

    // The first MDU cycle is spent in M_IDLE, so the busy counter is loaded
    // with two less than the total occupancy.
    localparam logic [3:0] MDU_LOAD   = 4'(MDU_CYCLES - 2);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mdu_state_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    mdu_state_t  mdu_state;
    halt_state_t halt_state;
    logic [3:0]  cnt;
    logic [3:0]  dcnt;

    logic        s1_load_use;
    logic        s2_mdu;
    logic        s3_mem;
    logic [4:0]  stall_raw;
    logic        halted;
    logic        active;
    logic        branch_flush;
    logic        halt_flush;
    logic        halt_accept;

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------
    // A taken branch squashes the ID instruction, so a load-use hazard
    // against it is irrelevant.
    assign s1_load_use = ex_mem_read && (ex_rd != 5'd0)
                       && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)))
                       && !ex_branch_taken;

    assign s2_mdu = ((mdu_state == M_IDLE) && ex_mdu_start) || (mdu_state == M_BUSY);
    assign s3_mem = mem_wait;

    // Only the deepest stall is reported; it already holds all younger stages.
    always_comb begin
        stall_raw = 5'b00000;
        if (s3_mem) begin
            stall_raw[3] = 1'b1;
        end else if (s2_mdu) begin
            stall_raw[2] = 1'b1;
        end else if (s1_load_use) begin
            stall_raw[1] = 1'b1;
        end
    end

    assign halted = (halt_state == HALTED);
    // Once halted the pipeline is empty, so every hazard source is masked.
    assign active = rst && !halted;

    // A branch held by a MEM or EX stall is redirected when the stall releases.
    assign branch_flush = active && ex_branch_taken && (stall_raw[3:2] == 2'b00);
    assign halt_flush   = rst && (halt_state != RUN);

    assign stall = active ? stall_raw : 5'b00000;
    assign flush = {3'b000, branch_flush, halt_flush};
    assign hlt   = rst && halted;

    assign halt_accept = id_halt && (stall_raw == 5'b00000) && !branch_flush;

    // ------------------------------------------------------------------
    // MDU occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdu_state <= M_IDLE;
            cnt       <= 4'd0;
        end else begin
            case (mdu_state)
                M_IDLE: begin
                    if (ex_mdu_start) begin
                        cnt       <= MDU_LOAD;
                        mdu_state <= (MDU_CYCLES == 2) ? M_DONE : M_BUSY;
                    end
                end
                M_BUSY: begin
                    // The MDU keeps computing even while MEM is held.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        mdu_state <= M_DONE;
                    end
                end
                M_DONE: begin
                    // The finished instruction stays in EX while MEM waits;
                    // its still-asserted start level must not re-trigger.
                    if (!mem_wait) begin
                        mdu_state <= M_IDLE;
                    end
                end
                default: begin
                    mdu_state <= M_IDLE;
                    cnt       <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Halt sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_state <= RUN;
            dcnt       <= 4'd0;
        end else begin
            case (halt_state)
                RUN: begin
                    if (halt_accept) begin
                        halt_state <= DRAIN;
                        dcnt       <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    // Drain progress only counts cycles in which MEM advances.
                    if (!stall_raw[3]) begin
                        dcnt <= dcnt - 4'd1;
                        if (dcnt == 4'd1) begin
                            halt_state <= HALTED;
                        end
                    end
                end
                HALTED: begin
                    halt_state <= HALTED;
                end
                default: begin
                    halt_state <= RUN;
                    dcnt       <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
